// File: rtl/dram_sched_pkg.sv
// Shared types and helpers for the per-channel DRAM command scheduler.
// Field widths here are the channel-wide defaults for address, id, length and timing.
package dram_sched_pkg;

   localparam int CMD_TYPE_W    = 3;
   localparam int DRAM_BA_WIDTH = 2;
   localparam int DRAM_RA_WIDTH = 14;
   localparam int DRAM_CA_WIDTH = 10;
   localparam int AXI_ID_WIDTH  = 4;
   localparam int AXI_LEN_WIDTH = 8;
   localparam int T_RRD_WIDTH   = 4;
   localparam int T_CCD_WIDTH   = 4;
   localparam int T_WTR_WIDTH   = 4;
   localparam int T_RTW_WIDTH   = 4;

   localparam int RR_MAX   = 32;
   localparam int RR_IDX_W = 5;

   typedef enum logic [CMD_TYPE_W-1:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } cmd_type_e;

   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0] searching upward from ptr+1, wrapping at n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int n);
      rr_pick_t res;
      int       j;
      res = '0;
      for (int i = 1; i <= RR_MAX; i++) begin
         if (i <= n) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (!res.valid && req[j[RR_IDX_W-1:0]]) begin
               res.valid = 1'b1;
               res.idx   = j[RR_IDX_W-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dram_cmd_scheduler_rr_arb.sv
// Round-robin arbiter: combinational one-hot pick, pointer moves to the winner on adv.
module sched_rr_arb
   import dram_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  gnt,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] ptr;
   rr_pick_t      pick;

   always_comb begin
      pick  = rr_pick(RR_MAX'(req), RR_IDX_W'(ptr), N);
      valid = pick.valid;
      idx   = IW'(pick.idx);
      for (int i = 0; i < N; i++) begin
         gnt[i] = pick.valid && (pick.idx == RR_IDX_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= idx;
      end
   end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Per-channel command arbiter: picks one ACT/RD/WR/PRE (or an all-bank REF) per cycle,
// enforces tRRD/tCCD/tWTR/tRTW between banks and registers the winner for the DFI encoder.
module dram_cmd_scheduler
   import dram_sched_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int BA_W      = DRAM_BA_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_BANKS-1:0]               act_req_i,
   input  logic [NUM_BANKS-1:0]               rd_req_i,
   input  logic [NUM_BANKS-1:0]               wr_req_i,
   input  logic [NUM_BANKS-1:0]               pre_req_i,
   input  logic [NUM_BANKS-1:0]               ref_req_i,
   input  logic [NUM_BANKS*DRAM_RA_WIDTH-1:0] ra_i,
   input  logic [NUM_BANKS*DRAM_CA_WIDTH-1:0] ca_i,
   input  logic [NUM_BANKS*AXI_ID_WIDTH-1:0]  id_i,
   input  logic [NUM_BANKS*AXI_LEN_WIDTH-1:0] len_i,
   output logic [NUM_BANKS-1:0]               act_gnt_o,
   output logic [NUM_BANKS-1:0]               rd_gnt_o,
   output logic [NUM_BANKS-1:0]               wr_gnt_o,
   output logic [NUM_BANKS-1:0]               pre_gnt_o,
   output logic [NUM_BANKS-1:0]               ref_gnt_o,
   input  logic [T_RRD_WIDTH-1:0]             t_rrd_m1,
   input  logic [T_CCD_WIDTH-1:0]             t_ccd_m1,
   input  logic [T_WTR_WIDTH-1:0]             t_wtr_m1,
   input  logic [T_RTW_WIDTH-1:0]             t_rtw_m1,
   output logic                               cmd_valid_o,
   output logic [CMD_TYPE_W-1:0]              cmd_type_o,
   output logic [BA_W-1:0]                    cmd_ba_o,
   output logic [DRAM_RA_WIDTH-1:0]           cmd_ra_o,
   output logic [DRAM_CA_WIDTH-1:0]           cmd_ca_o,
   output logic [AXI_ID_WIDTH-1:0]            cmd_id_o,
   output logic [AXI_LEN_WIDTH-1:0]           cmd_len_o
);

   localparam int RA_W  = DRAM_RA_WIDTH;
   localparam int CA_W  = DRAM_CA_WIDTH;
   localparam int ID_W  = AXI_ID_WIDTH;
   localparam int LEN_W = AXI_LEN_WIDTH;

   logic [T_RRD_WIDTH-1:0] rrd_cnt;
   logic [T_CCD_WIDTH-1:0] ccd_cnt;
   logic [T_WTR_WIDTH-1:0] wtr_cnt;
   logic [T_RTW_WIDTH-1:0] rtw_cnt;

   logic                 ref_all, ref_any, rd_ok, wr_ok, act_ok;
   logic [NUM_BANKS-1:0] cas_el, act_el, pre_el;
   logic [NUM_BANKS-1:0] cas_gnt, act_gnt, pre_gnt;
   logic                 cas_v, act_v, pre_v;
   logic                 cas_adv, act_adv, pre_adv;
   logic [BA_W-1:0]      cas_idx, act_idx, pre_idx, win_idx;
   cmd_type_e            nxt_type;
   logic                 issue;

   logic [RA_W-1:0]  sel_ra;
   logic [CA_W-1:0]  sel_ca;
   logic [ID_W-1:0]  sel_id;
   logic [LEN_W-1:0] sel_len;

   // A bank asserting both rd and wr is treated as a read; if the read is blocked the bank waits.
   always_comb begin
      ref_all = &ref_req_i;
      ref_any = |ref_req_i;
      rd_ok   = (ccd_cnt == '0) && (wtr_cnt == '0);
      wr_ok   = (ccd_cnt == '0) && (rtw_cnt == '0);
      act_ok  = (rrd_cnt == '0) && !ref_any;
      for (int b = 0; b < NUM_BANKS; b++) begin
         cas_el[b] = rd_req_i[b] ? rd_ok : (wr_req_i[b] && wr_ok);
      end
      act_el = act_req_i & {NUM_BANKS{act_ok}};
      pre_el = pre_req_i;
   end

   sched_rr_arb #(.N(NUM_BANKS)) u_cas_arb (
      .clk(clk), .rst(rst), .req(cas_el), .adv(cas_adv),
      .gnt(cas_gnt), .valid(cas_v), .idx(cas_idx)
   );

   sched_rr_arb #(.N(NUM_BANKS)) u_act_arb (
      .clk(clk), .rst(rst), .req(act_el), .adv(act_adv),
      .gnt(act_gnt), .valid(act_v), .idx(act_idx)
   );

   sched_rr_arb #(.N(NUM_BANKS)) u_pre_arb (
      .clk(clk), .rst(rst), .req(pre_el), .adv(pre_adv),
      .gnt(pre_gnt), .valid(pre_v), .idx(pre_idx)
   );

   always_comb begin
      act_gnt_o = '0;
      rd_gnt_o  = '0;
      wr_gnt_o  = '0;
      pre_gnt_o = '0;
      ref_gnt_o = '0;
      cas_adv   = 1'b0;
      act_adv   = 1'b0;
      pre_adv   = 1'b0;
      nxt_type  = CMD_NOP;
      win_idx   = '0;
      if (!rst) begin
         if (ref_all) begin
            ref_gnt_o = '1;
            nxt_type  = CMD_REF;
         end else if (cas_v) begin
            cas_adv = 1'b1;
            win_idx = cas_idx;
            if (rd_req_i[cas_idx]) begin
               rd_gnt_o = cas_gnt;
               nxt_type = CMD_RD;
            end else begin
               wr_gnt_o = cas_gnt;
               nxt_type = CMD_WR;
            end
         end else if (act_v) begin
            act_adv   = 1'b1;
            win_idx   = act_idx;
            act_gnt_o = act_gnt;
            nxt_type  = CMD_ACT;
         end else if (pre_v) begin
            pre_adv   = 1'b1;
            win_idx   = pre_idx;
            pre_gnt_o = pre_gnt;
            nxt_type  = CMD_PRE;
         end
      end
      issue = (nxt_type != CMD_NOP);
   end

   always_comb begin
      sel_ra  = '0;
      sel_ca  = '0;
      sel_id  = '0;
      sel_len = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (win_idx == BA_W'(b)) begin
            sel_ra  = ra_i[b*RA_W +: RA_W];
            sel_ca  = ca_i[b*CA_W +: CA_W];
            sel_id  = id_i[b*ID_W +: ID_W];
            sel_len = len_i[b*LEN_W +: LEN_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rrd_cnt <= '0;
         ccd_cnt <= '0;
         wtr_cnt <= '0;
         rtw_cnt <= '0;
      end else begin
         rrd_cnt <= (nxt_type == CMD_ACT) ? t_rrd_m1 :
                    (rrd_cnt == '0) ? '0 : rrd_cnt - 1'b1;
         ccd_cnt <= (nxt_type == CMD_RD || nxt_type == CMD_WR) ? t_ccd_m1 :
                    (ccd_cnt == '0) ? '0 : ccd_cnt - 1'b1;
         wtr_cnt <= (nxt_type == CMD_WR) ? t_wtr_m1 :
                    (wtr_cnt == '0) ? '0 : wtr_cnt - 1'b1;
         rtw_cnt <= (nxt_type == CMD_RD) ? t_rtw_m1 :
                    (rtw_cnt == '0) ? '0 : rtw_cnt - 1'b1;
      end
   end

   // REF carries no per-bank fields, so ra/ca/id/len keep the last real command's values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid_o <= 1'b0;
         cmd_type_o  <= CMD_NOP;
         cmd_ba_o    <= '0;
         cmd_ra_o    <= '0;
         cmd_ca_o    <= '0;
         cmd_id_o    <= '0;
         cmd_len_o   <= '0;
      end else begin
         cmd_valid_o <= issue;
         cmd_type_o  <= nxt_type;
         if (issue) begin
            cmd_ba_o <= win_idx;
            if (nxt_type != CMD_REF) begin
               cmd_ra_o  <= sel_ra;
               cmd_ca_o  <= sel_ca;
               cmd_id_o  <= sel_id;
               cmd_len_o <= sel_len;
            end
         end
      end
   end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed and randomized checks of dram_cmd_scheduler against an earliest-issue-cycle model.
module tb_dram_cmd_scheduler;
   import dram_sched_pkg::*;

   localparam int NB    = 4;
   localparam int BW    = DRAM_BA_WIDTH;
   localparam int RA_W  = DRAM_RA_WIDTH;
   localparam int CA_W  = DRAM_CA_WIDTH;
   localparam int ID_W  = AXI_ID_WIDTH;
   localparam int LEN_W = AXI_LEN_WIDTH;

   localparam logic [2:0] T_NOP = 3'd0, T_ACT = 3'd1, T_RD = 3'd2,
                          T_WR = 3'd3, T_PRE = 3'd4, T_REF = 3'd5;

   logic clk, rst;
   logic [NB-1:0] act_r, rd_r, wr_r, pre_r, ref_r;
   logic [NB*RA_W-1:0]  ra_r;
   logic [NB*CA_W-1:0]  ca_r;
   logic [NB*ID_W-1:0]  id_r;
   logic [NB*LEN_W-1:0] len_r;
   logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic [T_RRD_WIDTH-1:0] t_rrd;
   logic [T_CCD_WIDTH-1:0] t_ccd;
   logic [T_WTR_WIDTH-1:0] t_wtr;
   logic [T_RTW_WIDTH-1:0] t_rtw;
   logic            cmd_valid;
   logic [2:0]      cmd_type;
   logic [BW-1:0]   cmd_ba;
   logic [RA_W-1:0] cmd_ra;
   logic [CA_W-1:0] cmd_ca;
   logic [ID_W-1:0] cmd_id;
   logic [LEN_W-1:0] cmd_len;

   dram_cmd_scheduler #(.NUM_BANKS(NB), .BA_W(BW)) dut (
      .clk(clk), .rst(rst),
      .act_req_i(act_r), .rd_req_i(rd_r), .wr_req_i(wr_r), .pre_req_i(pre_r), .ref_req_i(ref_r),
      .ra_i(ra_r), .ca_i(ca_r), .id_i(id_r), .len_i(len_r),
      .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .pre_gnt_o(pre_gnt),
      .ref_gnt_o(ref_gnt),
      .t_rrd_m1(t_rrd), .t_ccd_m1(t_ccd), .t_wtr_m1(t_wtr), .t_rtw_m1(t_rtw),
      .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type), .cmd_ba_o(cmd_ba),
      .cmd_ra_o(cmd_ra), .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: earliest cycle at which each command kind may next issue.
   int cyc = 0;
   int nxt_act = 0, nxt_cas = 0, nxt_rd = 0, nxt_wr = 0;
   int ptr_cas = 0, ptr_act = 0, ptr_pre = 0;
   logic [NB-1:0] e_act, e_rd, e_wr, e_pre, e_ref;
   logic [NB-1:0] o_act, o_rd, o_wr, o_pre, o_ref;
   logic          e_valid;
   logic [2:0]    e_type;
   int            e_ba;
   logic [RA_W-1:0]  e_ra;
   logic [CA_W-1:0]  e_ca;
   logic [ID_W-1:0]  e_id;
   logic [LEN_W-1:0] e_len;
   logic             fields_known = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int rr(input logic [NB-1:0] el, input int ptr);
      for (int k = 1; k <= NB; k++) begin
         if (el[(ptr + k) % NB]) return (ptr + k) % NB;
      end
      return -1;
   endfunction

   // Called #1 after a rising edge with this cycle's inputs driven; returns #1 after the next edge.
   task automatic cycle();
      logic [NB-1:0] cas_el, act_el;
      int            w;
      logic          issued;
      logic [2:0]    typ;
      #1;
      e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
      issued = 1'b0;
      typ = T_NOP;
      w = -1;
      if (!rst) begin
         if (ref_r == '1) begin
            e_ref  = '1;
            issued = 1'b1;
            typ    = T_REF;
         end else begin
            for (int b = 0; b < NB; b++) begin
               cas_el[b] = rd_r[b] ? (cyc >= nxt_cas && cyc >= nxt_rd)
                                   : (wr_r[b] && cyc >= nxt_cas && cyc >= nxt_wr);
               act_el[b] = act_r[b] && cyc >= nxt_act && ref_r == '0;
            end
            w = rr(cas_el, ptr_cas);
            if (w >= 0) begin
               ptr_cas = w;
               issued  = 1'b1;
               nxt_cas = cyc + int'(t_ccd) + 1;
               if (rd_r[w]) begin
                  e_rd[w] = 1'b1; typ = T_RD; nxt_wr = cyc + int'(t_rtw) + 1;
               end else begin
                  e_wr[w] = 1'b1; typ = T_WR; nxt_rd = cyc + int'(t_wtr) + 1;
               end
            end else begin
               w = rr(act_el, ptr_act);
               if (w >= 0) begin
                  ptr_act = w; issued = 1'b1; e_act[w] = 1'b1; typ = T_ACT;
                  nxt_act = cyc + int'(t_rrd) + 1;
               end else begin
                  w = rr(pre_r, ptr_pre);
                  if (w >= 0) begin
                     ptr_pre = w; issued = 1'b1; e_pre[w] = 1'b1; typ = T_PRE;
                  end
               end
            end
         end
      end
      o_act = act_gnt; o_rd = rd_gnt; o_wr = wr_gnt; o_pre = pre_gnt; o_ref = ref_gnt;
      chk("act_gnt", 64'(o_act), 64'(e_act));
      chk("rd_gnt",  64'(o_rd),  64'(e_rd));
      chk("wr_gnt",  64'(o_wr),  64'(e_wr));
      chk("pre_gnt", 64'(o_pre), 64'(e_pre));
      chk("ref_gnt", 64'(o_ref), 64'(e_ref));
      if (issued) begin
         if (typ == T_REF) begin
            e_ba = 0;
            fields_known = 1'b0;
         end else begin
            e_ba  = w;
            e_ra  = ra_r[w*RA_W +: RA_W];
            e_ca  = ca_r[w*CA_W +: CA_W];
            e_id  = id_r[w*ID_W +: ID_W];
            e_len = len_r[w*LEN_W +: LEN_W];
            fields_known = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         ptr_cas = 0; ptr_act = 0; ptr_pre = 0;
         nxt_act = 0; nxt_cas = 0; nxt_rd = 0; nxt_wr = 0;
         e_valid = 1'b0; e_type = T_NOP;
         e_ba = 0; e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
         fields_known = 1'b1;
      end else begin
         e_valid = issued;
         e_type  = typ;
      end
      chk("cmd_valid", 64'(cmd_valid), 64'(e_valid));
      chk("cmd_type",  64'(cmd_type),  64'(e_type));
      chk("cmd_ba",    64'(cmd_ba),    64'(e_ba));
      if (fields_known) begin
         chk("cmd_ra",  64'(cmd_ra),  64'(e_ra));
         chk("cmd_ca",  64'(cmd_ca),  64'(e_ca));
         chk("cmd_id",  64'(cmd_id),  64'(e_id));
         chk("cmd_len", 64'(cmd_len), 64'(e_len));
      end
   endtask

   task automatic clear_reqs();
      act_r = '0; rd_r = '0; wr_r = '0; pre_r = '0; ref_r = '0;
   endtask

   task automatic rand_fields();
      for (int b = 0; b < NB; b++) begin
         ra_r[b*RA_W +: RA_W]    = RA_W'($urandom);
         ca_r[b*CA_W +: CA_W]    = CA_W'($urandom);
         id_r[b*ID_W +: ID_W]    = ID_W'($urandom);
         len_r[b*LEN_W +: LEN_W] = LEN_W'($urandom);
      end
   endtask

   task automatic do_reset();
      clear_reqs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int kind;
      rst = 1'b1;
      clear_reqs();
      rand_fields();
      t_rrd = 4'd3; t_ccd = 4'd0; t_wtr = 4'd0; t_rtw = 4'd0;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state, idle.
      cycle();
      chk("reset_valid", 64'(cmd_valid), 64'd0);
      chk("reset_type",  64'(cmd_type),  64'(T_NOP));

      // Single ACT from bank 2.
      act_r = 4'b0100;
      cycle();
      chk("act_single_gnt", 64'(o_act), 64'b0100);
      chk("act_single_ba", 64'(cmd_ba), 64'd2);
      chk("act_single_type", 64'(cmd_type), 64'(T_ACT));
      act_r = '0;

      // Two ACTs back to back under tRRD=4 cycles.
      do_reset();
      act_r = 4'b0011;
      cycle();
      chk("rrd_first", 64'(o_act), 64'b0010);
      act_r = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         cycle();
         chk("rrd_blocked", 64'(o_act), 64'd0);
      end
      cycle();
      chk("rrd_second", 64'(o_act), 64'b0001);
      act_r = '0;

      // Round-robin over all reads, tCCD=1.
      do_reset();
      t_ccd = 4'd0; t_rtw = 4'd2; t_wtr = 4'd2;
      rd_r = 4'b1111;
      cycle(); chk("rr_1", 64'(o_rd), 64'b0010);
      cycle(); chk("rr_2", 64'(o_rd), 64'b0100);
      cycle(); chk("rr_3", 64'(o_rd), 64'b1000);
      cycle(); chk("rr_0", 64'(o_rd), 64'b0001);
      rd_r = '0;

      // WR then RD under tWTR; PRE slips in while CAS is blocked.
      do_reset();
      t_wtr = 4'd5; t_ccd = 4'd1; t_rtw = 4'd0; t_rrd = 4'd0;
      wr_r = 4'b0001;
      cycle(); chk("wtr_wr", 64'(o_wr), 64'b0001);
      wr_r = '0; rd_r = 4'b0010; pre_r = 4'b1000;
      cycle(); chk("wtr_pre", 64'(o_pre), 64'b1000);
      pre_r = '0;
      for (int c = 2; c <= 5; c++) begin
         cycle();
         chk("wtr_blocked", 64'(o_rd), 64'd0);
      end
      cycle(); chk("wtr_rd", 64'(o_rd), 64'b0010);
      rd_r = '0;

      // RD then WR under tRTW.
      do_reset();
      t_rtw = 4'd2; t_ccd = 4'd0; t_wtr = 4'd0;
      rd_r = 4'b0001;
      cycle();
      rd_r = '0; wr_r = 4'b0010;
      cycle(); chk("rtw_blk1", 64'(o_wr), 64'd0);
      cycle(); chk("rtw_blk2", 64'(o_wr), 64'd0);
      cycle(); chk("rtw_wr", 64'(o_wr), 64'b0010);
      wr_r = '0;

      // Partial refresh blocks ACT; full refresh grants all banks together.
      ref_r = 4'b0111; act_r = 4'b1000;
      cycle();
      chk("ref_part_act", 64'(o_act), 64'd0);
      chk("ref_part_ref", 64'(o_ref), 64'd0);
      ref_r = 4'b1111;
      cycle();
      chk("ref_full", 64'(o_ref), 64'hf);
      chk("ref_type", 64'(cmd_type), 64'(T_REF));
      ref_r = '0;
      cycle(); chk("ref_after_act", 64'(o_act), 64'b1000);
      act_r = '0;

      // Reset in the cycle after an ACT clears tRRD.
      do_reset();
      t_rrd = 4'd3;
      act_r = 4'b0001;
      cycle();
      act_r = 4'b0010; rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_valid", 64'(cmd_valid), 64'd0);
      cycle();
      chk("rst_mid_act", 64'(o_act), 64'b0010);
      act_r = '0;

      // Randomized traffic under a few timing sets.
      for (int ph = 0; ph < 3; ph++) begin
         t_rrd = 4'($urandom_range(0, 6));
         t_ccd = 4'($urandom_range(0, 4));
         t_wtr = 4'($urandom_range(0, 7));
         t_rtw = 4'($urandom_range(0, 7));
         do_reset();
         repeat (500) begin
            rand_fields();
            cycle();
            act_r &= ~e_act; rd_r &= ~e_rd; wr_r &= ~e_wr; pre_r &= ~e_pre;
            if (e_ref == '1) ref_r = '0;
            for (int b = 0; b < NB; b++) begin
               if (!(act_r[b] | rd_r[b] | wr_r[b] | pre_r[b]) && $urandom_range(0, 2) == 0) begin
                  kind = $urandom_range(0, 4);
                  case (kind)
                     0: act_r[b] = 1'b1;
                     1: rd_r[b]  = 1'b1;
                     2: wr_r[b]  = 1'b1;
                     3: pre_r[b] = 1'b1;
                     default: begin rd_r[b] = 1'b1; wr_r[b] = 1'b1; end
                  endcase
               end
            end
            if (ref_r == '0) begin
               if ($urandom_range(0, 39) == 0)
                  ref_r = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1;
            end else if ($urandom_range(0, 3) == 0) begin
               ref_r = '1;
            end
         end
         clear_reqs();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Per-channel command arbiter between NUM_BANKS bank controllers (scheduler-request source side) and the DFI command path.
- Each cycle it selects at most one ACT/RD/WR/PRE, or one all-bank REF, and returns a one-hot grant to the winning bank.
- Enforces inter-bank timing tRRD, tCCD, tWTR and tRTW from the timing-configuration bundle.
- Registers the issued command for the DFI encoder.

Parameters:
- NUM_BANKS, 4, number of requesting bank controllers; one per DRAM bank; power of 2, at least 2.
- BA_W, `DRAM_BA_WIDTH, bank-address width; log2(NUM_BANKS).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- act_req_i / rd_req_i / wr_req_i / pre_req_i / ref_req_i  input  NUM_BANKS each  per-bank request lines.
- ra_i  input  NUM_BANKS*`DRAM_RA_WIDTH  per-bank row address.
- ca_i  input  NUM_BANKS*`DRAM_CA_WIDTH  per-bank column address.
- id_i  input  NUM_BANKS*`AXI_ID_WIDTH  per-bank transaction id.
- len_i  input  NUM_BANKS*`AXI_LEN_WIDTH  per-bank burst length.
- act_gnt_o / rd_gnt_o / wr_gnt_o / pre_gnt_o / ref_gnt_o  output  NUM_BANKS each  per-bank grants; combinational, same cycle as request.
- t_rrd_m1 / t_ccd_m1 / t_wtr_m1 / t_rtw_m1  input  `T_RRD/CCD/WTR/RTW_WIDTH  timing minus one; static while any request is pending.
- cmd_valid_o  output  1  registered command strobe.
- cmd_type_o  output  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE, 5=REF.
- cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o  output  BA_W / RA / CA / ID / LEN widths  registered command fields.

Behaviour:
- Reset: all grants and cmd_valid_o are 0; cmd_type_o is NOP; address, id and len fields are 0; all timing counters are 0; round-robin pointers are 0; last_cas is NONE.
- Grants are combinational, and at most one grant bit is set per cycle, except REF.
- A request must stay asserted until it is granted. The bank drops it in the cycle after the grant.
- Granted command appears on cmd_*_o exactly 1 cycle later, with cmd_valid_o=1 for one cycle. cmd_ba_o is the winner's index.
- Class priority, evaluated each cycle:
  - REF: only when ref_req_i is all ones. All ref_gnt bits assert together; cmd_ba_o=0.
  - CAS: RD or WR.
  - ACT.
  - PRE.
- While any ref_req_i bit is set, ACT is blocked. CAS and PRE continue so that banks can drain and close.
- Within the CAS, ACT and PRE classes: independent round-robin pointer per class. Search starts at ptr+1 mod NUM_BANKS. After a grant, ptr becomes the winner's index.
- CAS requires the winning bank to assert only one of rd/wr. If a bank asserts both, RD wins.
- Timing counters are down-counters that saturate at 0; a command is eligible when its counter is 0:
  - rrd_cnt: loaded with t_rrd_m1 on ACT issue; gates ACT.
  - ccd_cnt: loaded with t_ccd_m1 on any CAS issue; gates RD and WR.
  - wtr_cnt: loaded with t_wtr_m1 on WR issue; gates RD.
  - rtw_cnt: loaded with t_rtw_m1 on RD issue; gates WR.
- A load in cycle N gives counter value m1 in cycle N+1. The next same-type issue is allowed at N+m1+1.
- A command is issued in cycle N if its grant is high in cycle N.
- Ineligible requesters are skipped, and the next eligible bank in the same class may win. Blocked CAS does not block lower classes:
  - if no CAS is eligible, ACT may issue;
  - if neither CAS nor ACT is eligible, PRE may issue.
- PRE and REF have no inter-bank timing here; the bank controllers own tRP and tRFC.
- Counters keep decrementing while REF is in progress.
- rst asserted mid-operation returns everything to reset values in the next cycle. Pending in-flight commands are dropped.
- No request or ineligible request gives cmd_valid_o=0 and cmd_type_o=NOP. Fields hold their last value.

Decomposition:
- Package dram_sched_pkg holds:
  - cmd_type_e enum: NOP, ACT, RD, WR, PRE, REF.
  - CMD_TYPE_W=3.
  - function rr_pick(req vector, ptr) returning valid and index.
- Sub-module sched_rr_arb (parameter N), instantiated three times, for the CAS, ACT and PRE classes:
  - combinational one-hot pick;
  - registered pointer that updates on the `adv` input.
- Timing counters and priority mux live in the top module.

Test Plan:
- Single ACT from bank 2, t_rrd_m1=3 -> act_gnt_o=4'b0100 in cycle 0. Cycle 1: cmd_type_o=ACT, cmd_ba_o=2, cmd_valid_o=1.
- ACT requests from banks 0 and 1 held together, t_rrd_m1=3 -> bank 1 granted at cycle 0, bank 0 at cycle 4. No ACT grant in cycles 1-3.
- Round-robin: RD requests from all 4 banks, held and re-asserted after each grant, t_ccd_m1=0 -> grant order 1,2,3,0 on consecutive cycles.
- WR from bank 0 at cycle 0, then RD from bank 1, t_wtr_m1=5, t_ccd_m1=1 -> RD granted at cycle 6. A PRE request from bank 3 pending in cycle 1 is granted in cycle 1.
- RD at cycle 0, then WR, t_rtw_m1=2 -> WR granted at cycle 3. ref_req_i=4'b0111 with ACT pending on bank 3 -> no ACT or REF. ref_req_i=4'b1111 -> all ref_gnt bits high in the same cycle, cmd_type_o=REF next cycle.
- rst asserted one cycle after an ACT grant with rrd_cnt=3 -> cycle after reset release: cmd_valid_o=0, and a new ACT is granted immediately (rrd_cnt=0).
